id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage MIPS datapath.
- Latches the decoded operands and controls, and drives Rs_E/Rt_E/RegWrDst/RegWr into the EX-stage forwarding logic.
- Detects load-use hazards against the instruction currently in EX, inserts a one-cycle bubble, and freezes IF/ID.
- Also handles branch flush, an external pipeline freeze, and a saturating bubble counter for performance debug.

Parameters:
- DW, 32, datapath width of operand and immediate fields.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Valid_D  input  1  ID holds a real instruction.
- Rs_D  input  5  source register 1 address.
- Rt_D  input  5  source register 2 address.
- Rd_D  input  5  R-type destination address.
- UseRs_D  input  1  instruction reads Rs.
- UseRt_D  input  1  instruction reads Rt.
- RegWr_D  input  1  register write enable.
- RegDst_D  input  1  1: destination = Rd_D; 0: destination = Rt_D.
- MemToReg_D  input  1  instruction is a load.
- MemWr_D  input  1  instruction is a store.
- ALUSrc_D  input  1  ALU B operand select.
- ALUCtrl_D  input  4  ALU operation.
- ReadData1_D  input  DW  register-file Rs value.
- ReadData2_D  input  DW  register-file Rt value.
- Imm_D  input  DW  extended immediate.
- Flush_E  input  1  branch/jump resolved taken; squash the ID instruction.
- Freeze  input  1  external stall (memory busy); hold all state.
- Valid_E, Rs_E, Rt_E, RegWrDst_E, RegWr_E, MemToReg_E, MemWr_E, ALUSrc_E, ALUCtrl_E, ReadData1_E, ReadData2_E, Imm_E  output  (widths as the D-side counterparts; RegWrDst_E 5)  registered EX-stage copies.
- Stall_F  output  1  hold the PC (combinational).
- Stall_D  output  1  hold IF/ID (combinational).
- BubbleCnt  output  CNT_W  bubbles inserted since reset.

Behaviour:
- Reset: asynchronous, active-low. All registered outputs are 0 and BubbleCnt is 0. The bubble state is Valid_E=0, RegWr_E=0, MemWr_E=0, MemToReg_E=0.
- Load-use hazard (combinational): LU = Valid_D & Valid_E & MemToReg_E & RegWr_E & (RegWrDst_E != 0) & ((UseRs_D & Rs_D == RegWrDst_E) | (UseRt_D & Rt_D == RegWrDst_E)).
- Stall outputs: Stall_F = Stall_D = (LU & ~Flush_E) | Freeze.
- Each rising edge, apply the first matching priority:
  1. Freeze=1: hold every register and BubbleCnt.
  2. Flush_E=1: load a bubble; BubbleCnt +1.
  3. LU=1: load a bubble; BubbleCnt +1.
  4. Otherwise: load all D-side fields.
- Field loading rules:
  - RegWrDst_E <= RegDst_D ? Rd_D : Rt_D.
  - Valid_E <= Valid_D.
  - RegWr_E, MemWr_E and MemToReg_E are gated with Valid_D.
- Bubble contents: control bits are cleared. Data, address and ALUCtrl fields are also zeroed, so Rs_E = Rt_E = 0, which guarantees forwarding selects 00.
- Latency: one cycle from D-side inputs to E-side outputs. A load-use stall costs exactly one bubble. After the bubble, the load sits in MEM and the hazard clears, so the stalled instruction enters EX on the next edge with Stall_F/Stall_D deasserted.
- BubbleCnt saturates at 2^CNT_W-1 and never wraps.
- Flush_E and LU in the same cycle: flush wins. Stall_D=0 so IF/ID accepts the fetch redirect; exactly one bubble is counted.
- Freeze and LU together: Freeze wins. Nothing changes; LU is re-evaluated after Freeze drops.
- Destination register 0: a load with RegWrDst_E=0 never causes a stall.
- Reset asserted mid-stall: all state clears immediately. After reset, Stall_F/Stall_D follow from the cleared state (0 unless Freeze=1).

Test Plan:
- Basic pass-through: reset, then drive add $3,$1,$2 (Rs=1, Rt=2, Rd=3, RegDst=1, RegWr=1, ReadData1=5) -> next edge Rs_E=1, Rt_E=2, RegWrDst_E=3, RegWr_E=1, ReadData1_E=5, Valid_E=1, Stall_F=0.
- Load-use: lw $4 in EX (MemToReg_E=1, RegWrDst_E=4), ID add with Rs_D=4, UseRs_D=1 -> Stall_F=Stall_D=1 that cycle; next edge Valid_E=0, RegWr_E=0, BubbleCnt=1; following edge add enters EX with Rs_E=4 and the stall deasserted.
- False hazard filters:
  - Same case with UseRs_D=0 and Rt_D≠4 -> no stall.
  - lw to $0 -> no stall.
- Flush vs LU: load-use condition plus Flush_E=1 -> Stall_D=0; bubble inserted; BubbleCnt increments by exactly 1.
- Freeze: Freeze=1 for 3 cycles while D inputs change -> all E outputs and BubbleCnt unchanged, Stall_F=1; release -> the current D values load on the next edge.
- Saturation and async reset:
  - With CNT_W=2, force 5 flushes -> BubbleCnt sticks at 3.
  - Drop rst_n between clock edges -> outputs go to 0 before the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Inserts bubbles on load-use hazards and branch flushes, holds on Freeze, counts bubbles.
module id_ex_stage #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Valid_D,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic [4:0]       Rd_D,
  input  logic             UseRs_D,
  input  logic             UseRt_D,
  input  logic             RegWr_D,
  input  logic             RegDst_D,
  input  logic             MemToReg_D,
  input  logic             MemWr_D,
  input  logic             ALUSrc_D,
  input  logic [3:0]       ALUCtrl_D,
  input  logic [DW-1:0]    ReadData1_D,
  input  logic [DW-1:0]    ReadData2_D,
  input  logic [DW-1:0]    Imm_D,
  input  logic             Flush_E,
  input  logic             Freeze,
  output logic             Valid_E,
  output logic [4:0]       Rs_E,
  output logic [4:0]       Rt_E,
  output logic [4:0]       RegWrDst_E,
  output logic             RegWr_E,
  output logic             MemToReg_E,
  output logic             MemWr_E,
  output logic             ALUSrc_E,
  output logic [3:0]       ALUCtrl_E,
  output logic [DW-1:0]    ReadData1_E,
  output logic [DW-1:0]    ReadData2_E,
  output logic [DW-1:0]    Imm_E,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic [CNT_W-1:0] BubbleCnt
);

  logic             r_valid;
  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [4:0]       r_reg_wr_dst;
  logic             r_reg_wr;
  logic             r_mem_to_reg;
  logic             r_mem_wr;
  logic             r_alu_src;
  logic [3:0]       r_alu_ctrl;
  logic [DW-1:0]    r_rd1;
  logic [DW-1:0]    r_rd2;
  logic [DW-1:0]    r_imm;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic             w_lu;
  logic             w_bubble;
  logic             w_cnt_sat;

  // Load in EX whose destination is read by the ID instruction; $0 never hazards.
  assign w_lu = Valid_D & r_valid & r_mem_to_reg & r_reg_wr & (r_reg_wr_dst != 5'd0) &
                ((UseRs_D & (Rs_D == r_reg_wr_dst)) | (UseRt_D & (Rt_D == r_reg_wr_dst)));

  assign w_bubble  = Flush_E | w_lu;
  assign w_cnt_sat = (r_bubble_cnt == {CNT_W{1'b1}});

  assign Stall_F = (w_lu & ~Flush_E) | Freeze;
  assign Stall_D = (w_lu & ~Flush_E) | Freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_reg_wr_dst <= '0;
      r_reg_wr     <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_bubble_cnt <= '0;
    end else if (Freeze) begin
      r_valid <= r_valid;
    end else if (w_bubble) begin
      // Zeroed Rs/Rt keep forwarding muxes on the register-file path.
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_reg_wr_dst <= '0;
      r_reg_wr     <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      if (!w_cnt_sat) r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end else begin
      r_valid      <= Valid_D;
      r_rs         <= Rs_D;
      r_rt         <= Rt_D;
      r_reg_wr_dst <= RegDst_D ? Rd_D : Rt_D;
      r_reg_wr     <= RegWr_D & Valid_D;
      r_mem_to_reg <= MemToReg_D & Valid_D;
      r_mem_wr     <= MemWr_D & Valid_D;
      r_alu_src    <= ALUSrc_D;
      r_alu_ctrl   <= ALUCtrl_D;
      r_rd1        <= ReadData1_D;
      r_rd2        <= ReadData2_D;
      r_imm        <= Imm_D;
    end
  end

  assign Valid_E     = r_valid;
  assign Rs_E        = r_rs;
  assign Rt_E        = r_rt;
  assign RegWrDst_E  = r_reg_wr_dst;
  assign RegWr_E     = r_reg_wr;
  assign MemToReg_E  = r_mem_to_reg;
  assign MemWr_E     = r_mem_wr;
  assign ALUSrc_E    = r_alu_src;
  assign ALUCtrl_E   = r_alu_ctrl;
  assign ReadData1_E = r_rd1;
  assign ReadData2_E = r_rd2;
  assign Imm_E       = r_imm;
  assign BubbleCnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the EX-stage register contents.
module tb_id_ex_stage;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic Valid_D, UseRs_D, UseRt_D, RegWr_D, RegDst_D, MemToReg_D, MemWr_D, ALUSrc_D;
  logic [4:0] Rs_D, Rt_D, Rd_D;
  logic [3:0] ALUCtrl_D;
  logic [DW-1:0] ReadData1_D, ReadData2_D, Imm_D;
  logic Flush_E, Freeze;
  logic Valid_E, RegWr_E, MemToReg_E, MemWr_E, ALUSrc_E, Stall_F, Stall_D;
  logic [4:0] Rs_E, Rt_E, RegWrDst_E;
  logic [3:0] ALUCtrl_E;
  logic [DW-1:0] ReadData1_E, ReadData2_E, Imm_E;
  logic [CNT_W-1:0] BubbleCnt;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: the instruction currently in EX, or a bubble.
  logic       m_valid, m_regwr, m_m2r, m_memwr, m_alusrc;
  logic [4:0] m_rs, m_rt, m_dst;
  logic [3:0] m_alu;
  logic [DW-1:0] m_rd1, m_rd2, m_imm;
  int         m_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Valid_D(Valid_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .UseRs_D(UseRs_D), .UseRt_D(UseRt_D), .RegWr_D(RegWr_D), .RegDst_D(RegDst_D),
    .MemToReg_D(MemToReg_D), .MemWr_D(MemWr_D), .ALUSrc_D(ALUSrc_D), .ALUCtrl_D(ALUCtrl_D),
    .ReadData1_D(ReadData1_D), .ReadData2_D(ReadData2_D), .Imm_D(Imm_D),
    .Flush_E(Flush_E), .Freeze(Freeze), .Valid_E(Valid_E), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .RegWrDst_E(RegWrDst_E), .RegWr_E(RegWr_E), .MemToReg_E(MemToReg_E), .MemWr_E(MemWr_E),
    .ALUSrc_E(ALUSrc_E), .ALUCtrl_E(ALUCtrl_E), .ReadData1_E(ReadData1_E),
    .ReadData2_E(ReadData2_E), .Imm_E(Imm_E), .Stall_F(Stall_F), .Stall_D(Stall_D),
    .BubbleCnt(BubbleCnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic void model_clear();
    m_valid = 0; m_regwr = 0; m_m2r = 0; m_memwr = 0; m_alusrc = 0;
    m_rs = 0; m_rt = 0; m_dst = 0; m_alu = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
  endfunction

  // Does the ID instruction read the register the EX load is about to write?
  function automatic bit model_lu();
    bit reads;
    if (!(Valid_D && m_valid && m_m2r && m_regwr) || m_dst == 0) return 0;
    reads = (UseRs_D && Rs_D == m_dst) || (UseRt_D && Rt_D == m_dst);
    return reads;
  endfunction

  function automatic bit model_stall();
    return (model_lu() && !Flush_E) || Freeze;
  endfunction

  function automatic void model_edge();
    if (Freeze) return;
    if (Flush_E || model_lu()) begin
      model_clear();
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else begin
      m_valid = Valid_D; m_rs = Rs_D; m_rt = Rt_D;
      m_dst   = RegDst_D ? Rd_D : Rt_D;
      m_regwr = RegWr_D && Valid_D; m_m2r = MemToReg_D && Valid_D;
      m_memwr = MemWr_D && Valid_D; m_alusrc = ALUSrc_D; m_alu = ALUCtrl_D;
      m_rd1 = ReadData1_D; m_rd2 = ReadData2_D; m_imm = Imm_D;
    end
  endfunction

  task automatic check_outputs(input string ctx);
    check({ctx, ".Valid_E"}, 64'(Valid_E), 64'(m_valid));
    check({ctx, ".Rs_E"}, 64'(Rs_E), 64'(m_rs));
    check({ctx, ".Rt_E"}, 64'(Rt_E), 64'(m_rt));
    check({ctx, ".RegWrDst_E"}, 64'(RegWrDst_E), 64'(m_dst));
    check({ctx, ".RegWr_E"}, 64'(RegWr_E), 64'(m_regwr));
    check({ctx, ".MemToReg_E"}, 64'(MemToReg_E), 64'(m_m2r));
    check({ctx, ".MemWr_E"}, 64'(MemWr_E), 64'(m_memwr));
    check({ctx, ".ALUSrc_E"}, 64'(ALUSrc_E), 64'(m_alusrc));
    check({ctx, ".ALUCtrl_E"}, 64'(ALUCtrl_E), 64'(m_alu));
    check({ctx, ".ReadData1_E"}, 64'(ReadData1_E), 64'(m_rd1));
    check({ctx, ".ReadData2_E"}, 64'(ReadData2_E), 64'(m_rd2));
    check({ctx, ".Imm_E"}, 64'(Imm_E), 64'(m_imm));
    check({ctx, ".BubbleCnt"}, 64'(BubbleCnt), 64'(m_cnt));
  endtask

  task automatic check_stall(input string ctx);
    check({ctx, ".Stall_F"}, 64'(Stall_F), 64'(model_stall()));
    check({ctx, ".Stall_D"}, 64'(Stall_D), 64'(model_stall()));
  endtask

  // Check stalls with current inputs, clock one edge, then check the E side.
  task automatic step(input string ctx);
    #1;
    check_stall(ctx);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(ctx);
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic urs, input logic urt,
                           input logic rw, input logic rdst, input logic m2r, input logic mw);
    Valid_D = v; Rs_D = rs; Rt_D = rt; Rd_D = rd; UseRs_D = urs; UseRt_D = urt;
    RegWr_D = rw; RegDst_D = rdst; MemToReg_D = m2r; MemWr_D = mw;
  endtask

  task automatic randomize_data();
    ALUSrc_D = 1'($urandom); ALUCtrl_D = 4'($urandom);
    ReadData1_D = $urandom; ReadData2_D = $urandom; Imm_D = $urandom;
  endtask

  initial begin
    rst_n = 0; Flush_E = 0; Freeze = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ALUSrc_D = 0; ALUCtrl_D = 0; ReadData1_D = 0; ReadData2_D = 0; Imm_D = 0;
    model_clear(); m_cnt = 0;

    // Reset state
    #12;
    check_outputs("reset");
    check_stall("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Pass-through: add $3,$1,$2
    set_instr(1, 1, 2, 3, 1, 1, 1, 1, 0, 0);
    ALUCtrl_D = 4'h2; ReadData1_D = 5; ReadData2_D = 7; Imm_D = 0;
    step("add");
    check("add.Rs_E_const", 64'(Rs_E), 64'd1);
    check("add.RegWrDst_E_const", 64'(RegWrDst_E), 64'd3);
    check("add.ReadData1_E_const", 64'(ReadData1_E), 64'd5);

    // Load-use: lw $4 then add reading $4
    set_instr(1, 1, 4, 0, 1, 0, 1, 0, 1, 0);
    step("lw4");
    set_instr(1, 4, 2, 5, 1, 1, 1, 1, 0, 0);
    #1;
    check("lu.Stall_F_const", 64'(Stall_F), 64'd1);
    step("lu_bubble");
    check("lu.Valid_E_const", 64'(Valid_E), 64'd0);
    check("lu.BubbleCnt_const", 64'(BubbleCnt), 64'd1);
    step("lu_enter");
    check("lu.Rs_E_const", 64'(Rs_E), 64'd4);
    check("lu.Stall_D_after", 64'(Stall_D), 64'd0);

    // False hazard: UseRs=0 and Rt differs
    set_instr(1, 1, 4, 0, 1, 0, 1, 0, 1, 0);
    step("lw4b");
    set_instr(1, 4, 5, 6, 0, 1, 1, 1, 0, 0);
    #1;
    check("nouse.Stall_F_const", 64'(Stall_F), 64'd0);
    step("nouse");

    // False hazard: load to $0
    set_instr(1, 1, 0, 0, 1, 0, 1, 0, 1, 0);
    step("lw0");
    set_instr(1, 0, 0, 6, 1, 1, 1, 1, 0, 0);
    #1;
    check("r0.Stall_F_const", 64'(Stall_F), 64'd0);
    step("r0");

    // Flush beats load-use
    set_instr(1, 1, 4, 0, 1, 0, 1, 0, 1, 0);
    step("lw4c");
    set_instr(1, 4, 2, 5, 1, 1, 1, 1, 0, 0);
    Flush_E = 1;
    #1;
    check("flush.Stall_D_const", 64'(Stall_D), 64'd0);
    step("flush_lu");
    check("flush.BubbleCnt_const", 64'(BubbleCnt), 64'd2);
    Flush_E = 0;
    step("after_flush");

    // Freeze for 3 cycles with changing D inputs
    Freeze = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 5'($urandom), 5'($urandom), 5'($urandom), 1, 1, 1, 1, 0, 0);
      randomize_data();
      step("freeze");
      check("freeze.Stall_F_const", 64'(Stall_F), 64'd1);
    end
    Freeze = 0;
    step("unfreeze");

    // Saturation at 2^CNT_W-1
    Flush_E = 1;
    for (int i = 0; i < 5; i++) step("sat");
    check("sat.BubbleCnt_const", 64'(BubbleCnt), 64'd3);
    Flush_E = 0;

    // Async reset mid-stall
    set_instr(1, 1, 4, 0, 1, 0, 1, 0, 1, 0);
    step("lw4d");
    set_instr(1, 4, 2, 5, 1, 1, 1, 1, 0, 0);
    #1;
    check("rst.Stall_pre", 64'(Stall_F), 64'd1);
    #1;
    rst_n = 0;
    model_clear(); m_cnt = 0;
    #1;
    check_outputs("async_rst");
    check_stall("async_rst");
    check("rst.BubbleCnt_const", 64'(BubbleCnt), 64'd0);
    #1;
    rst_n = 1;
    step("post_rst");

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_instr(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      randomize_data();
      Flush_E = ($urandom_range(0, 9) == 0);
      Freeze  = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    Flush_E = 0; Freeze = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
